// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch counter: FSM encoding,
// BCD digit width, digit moduli and the default 10 ms divider.
package stopwatch_pkg;

    localparam int DIGIT_W     = 4;
    localparam int MOD_DEC     = 10;
    localparam int MOD_SEX     = 6;
    localparam int CLK_DIV_DEF = 500000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Key-control levels in, BCD display digits and status out.
// master = key control / bench side, slave = stopwatch_counter.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic   start;
    logic   clear;
    digit_t cs_ones;
    digit_t cs_tens;
    digit_t sec_ones;
    digit_t sec_tens;
    digit_t min_ones;
    digit_t min_tens;
    logic   running;
    logic   ovf;
    logic   tick;

    modport master (
        output start, clear,
        input  cs_ones, cs_tens, sec_ones, sec_tens,
        input  min_ones, min_tens, running, ovf, tick
    );

    modport slave (
        input  start, clear,
        output cs_ones, cs_tens, sec_ones, sec_tens,
        output min_ones, min_tens, running, ovf, tick
    );

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch chain: counts on carry-in,
// wraps at MODULUS and passes the carry on.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = MOD_DEC
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   cin,
    output digit_t q,
    output logic   cout
);

    localparam digit_t QMAX = digit_t'(MODULUS - 1);

    digit_t d;

    assign cout = cin && (q == QMAX);

    assign d = clr  ? '0 :
               cout ? '0 :
               cin  ? q + digit_t'(1) :
                      q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS.cc stopwatch: IDLE/RUN/PAUSE control, 10 ms prescaler
// and a six-digit BCD chain with sticky overflow.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter bit MIN_WRAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    stopwatch_counter_if.slave  bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc;
    logic          is_run;
    logic          tick;
    logic          at_max;
    logic          cin0;
    logic          ovf;
    logic          ovf_set;
    logic [5:0]    c;
    digit_t        co, ct, so, st, mo, mt;

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            bus.clear:
                state_nxt = S_IDLE;
            !bus.clear && bus.start:
                state_nxt = S_RUN;
            !bus.clear && !bus.start:
                state_nxt = (state == S_IDLE) ? S_IDLE : S_PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign is_run = (state == S_RUN);
    assign tick   = is_run && (presc == PMAX);

    // Prescaler only moves in RUN so a pause keeps the partial tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         presc <= '0;
        else if (bus.clear) presc <= '0;
        else if (is_run)    presc <= (presc == PMAX) ? '0 : presc + PW'(1);
    end

    assign at_max = ({mt, mo, st, so, ct, co} == 24'h595999);
    assign cin0   = tick && (MIN_WRAP || !at_max);

    bcd_digit #(.MODULUS(MOD_DEC)) u_cs_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(cin0), .q(co), .cout(c[0])
    );
    bcd_digit #(.MODULUS(MOD_DEC)) u_cs_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(c[0]), .q(ct), .cout(c[1])
    );
    bcd_digit #(.MODULUS(MOD_DEC)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(c[1]), .q(so), .cout(c[2])
    );
    bcd_digit #(.MODULUS(MOD_SEX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(c[2]), .q(st), .cout(c[3])
    );
    bcd_digit #(.MODULUS(MOD_DEC)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(c[3]), .q(mo), .cout(c[4])
    );
    bcd_digit #(.MODULUS(MOD_SEX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(bus.clear),
        .cin(c[4]), .q(mt), .cout(c[5])
    );

    // In saturate mode the chain is frozen, so detect the event directly.
    assign ovf_set = MIN_WRAP ? c[5] : (tick && at_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ovf <= 1'b0;
        else if (bus.clear) ovf <= 1'b0;
        else if (ovf_set)   ovf <= 1'b1;
    end

    assign bus.cs_ones  = co;
    assign bus.cs_tens  = ct;
    assign bus.sec_ones = so;
    assign bus.sec_tens = st;
    assign bus.min_ones = mo;
    assign bus.min_tens = mt;
    assign bus.running  = is_run;
    assign bus.tick     = tick;
    assign bus.ovf      = ovf;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with CLK_DIV=4; one instance
// wraps at 59:59.99, a second one saturates.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    stopwatch_counter_if bus0 ();
    stopwatch_counter_if bus1 ();

    assign bus1.start = bus0.start;
    assign bus1.clear = bus0.clear;

    stopwatch_counter #(.CLK_DIV(4), .MIN_WRAP(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    stopwatch_counter #(.CLK_DIV(4), .MIN_WRAP(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] dig0, dig1, pre_v;
    assign dig0 = {bus0.min_tens, bus0.min_ones, bus0.sec_tens,
                   bus0.sec_ones, bus0.cs_tens, bus0.cs_ones};
    assign dig1 = {bus1.min_tens, bus1.min_ones, bus1.sec_tens,
                   bus1.sec_ones, bus1.cs_tens, bus1.cs_ones};

    typedef struct {
        logic       start;
        logic       clear;
        logic       run;
        logic       tck;
        logic       ovf;
        logic [7:0] cs;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Loads pre_v into both counters through the digit next-state nets.
    task automatic preload();
        force dut0.u_cs_ones.d  = pre_v[3:0];
        force dut0.u_cs_tens.d  = pre_v[7:4];
        force dut0.u_sec_ones.d = pre_v[11:8];
        force dut0.u_sec_tens.d = pre_v[15:12];
        force dut0.u_min_ones.d = pre_v[19:16];
        force dut0.u_min_tens.d = pre_v[23:20];
        force dut1.u_cs_ones.d  = pre_v[3:0];
        force dut1.u_cs_tens.d  = pre_v[7:4];
        force dut1.u_sec_ones.d = pre_v[11:8];
        force dut1.u_sec_tens.d = pre_v[15:12];
        force dut1.u_min_ones.d = pre_v[19:16];
        force dut1.u_min_tens.d = pre_v[23:20];
        @(posedge clk);
        #1;
        release dut0.u_cs_ones.d;
        release dut0.u_cs_tens.d;
        release dut0.u_sec_ones.d;
        release dut0.u_sec_tens.d;
        release dut0.u_min_ones.d;
        release dut0.u_min_tens.d;
        release dut1.u_cs_ones.d;
        release dut1.u_cs_tens.d;
        release dut1.u_sec_ones.d;
        release dut1.u_sec_tens.d;
        release dut1.u_min_ones.d;
        release dut1.u_min_tens.d;
        @(negedge clk);
    endtask

    // From any state: clear, run one cycle, pause with prescaler=1.
    task automatic goto_pause();
        bus0.clear = 1'b1; bus0.start = 1'b0; tk(1);
        bus0.clear = 1'b0; bus0.start = 1'b1; tk(1);
        bus0.start = 1'b0; tk(1);
    endtask

    initial begin
        int  nt;
        bit  seen;
        bit  frozen;

        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus0.start = 1'b0;
        bus0.clear = 1'b0;
        pre_v      = '0;

        //           start clear run  tick ovf  cs
        vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vt[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vt[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
        vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02};
        vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        #3;
        chk("reset_state", {5'(0), bus0.running, bus0.tick,
            bus0.ovf, dig0}, 32'h0);
        #9 rst_n = 1'b1;
        tk(1);

        for (int i = 0; i < 15; i++) begin
            bus0.start = vt[i].start;
            bus0.clear = vt[i].clear;
            tk(1);
            chk($sformatf("vec%0d", i),
                {21'(0), bus0.running, bus0.tick, bus0.ovf,
                 bus0.cs_tens, bus0.cs_ones},
                {21'(0), vt[i].run, vt[i].tck, vt[i].ovf, vt[i].cs});
        end

        // 40 RUN cycles give 10 ticks and 00:00.10
        bus0.clear = 1'b1; tk(1);
        bus0.clear = 1'b0; bus0.start = 1'b1; tk(1);
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.tick) nt++;
            tk(1);
        end
        chk("tick_count_40", 32'(nt), 32'd10);
        chk("digits_after_40", {8'(0), dig0}, 32'h000010);
        chk("running_after_40", {31'(0), bus0.running}, 32'd1);

        // pause with prescaler=2, resume two cycles before the tick
        bus0.clear = 1'b1; bus0.start = 1'b0; tk(1);
        bus0.clear = 1'b0; bus0.start = 1'b1; tk(6);
        bus0.start = 1'b0;
        frozen = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tk(1);
            if (dig0 != 24'h000001 || bus0.tick || bus0.running)
                frozen = 1'b0;
        end
        chk("pause_frozen", {31'(0), frozen}, 32'd1);
        bus0.start = 1'b1; tk(1);
        chk("resume_tick_c1", {31'(0), bus0.tick}, 32'd0);
        tk(1);
        chk("resume_tick_c2", {31'(0), bus0.tick}, 32'd1);
        tk(1);
        chk("resume_digits", {8'(0), dig0}, 32'h000002);

        // 59:59.99 -> wrap on dut0, saturate on dut1
        goto_pause();
        pre_v = 24'h595999;
        preload();
        chk("preload_max", {8'(0), dig0}, {8'(0), dig1});
        chk("preload_max0", {8'(0), dig0}, 32'h595999);
        chk("ovf_before", {30'(0), bus0.ovf, bus1.ovf}, 32'd0);
        bus0.start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tk(1);
            seen = bus0.tick;
        end
        chk("wrap_tick_seen", {31'(0), seen}, 32'd1);
        tk(1);
        chk("wrap_digits", {8'(0), dig0}, 32'h000000);
        chk("wrap_ovf_run", {30'(0), bus0.ovf, bus0.running}, 32'd3);
        chk("sat_digits", {8'(0), dig1}, 32'h595999);
        chk("sat_ovf_run", {30'(0), bus1.ovf, bus1.running}, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tk(1);
            seen = bus1.tick;
        end
        chk("sat_tick_again", {31'(0), seen}, 32'd1);
        tk(1);
        chk("sat_hold", {8'(0), dig1}, 32'h595999);
        chk("wrap_continue", {8'(0), dig0}, 32'h000001);

        // start and clear together while running
        bus0.clear = 1'b1; tk(1);
        chk("clr_start_run", {30'(0), bus0.running, bus0.ovf}, 32'd0);
        chk("clr_start_dig", {8'(0), dig0}, 32'h000000);
        chk("clr_start_ovf1", {31'(0), bus1.ovf}, 32'd0);

        // clear in PAUSE at 00:12.34, then count from zero
        goto_pause();
        pre_v = 24'h001234;
        preload();
        chk("pause_1234", {7'(0), bus0.running, dig0}, 32'h001234);
        bus0.clear = 1'b1; tk(1);
        chk("pause_clear", {7'(0), bus0.running, dig0}, 32'h0);
        bus0.clear = 1'b0; bus0.start = 1'b1; tk(5);
        chk("count_from_zero", {7'(0), bus0.running, dig0}, 32'h1000001);

        // asynchronous reset mid-count
        tk(8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {5'(0), bus0.running, bus0.tick,
            bus0.ovf, dig0}, 32'h0);
        bus0.start = 1'b0;
        #3 rst_n = 1'b1;
        tk(1);
        chk("after_reset_idle", {7'(0), bus0.running, dig0}, 32'h0);
        bus0.start = 1'b1; tk(1);
        chk("restart_run", {7'(0), bus0.running, dig0}, 32'h1000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
